n64_dd_regs: RTL and testbench

- Parametrised successor to the minimal 64DD bus responder.
- Decodes the N64 PI 64DD register window and returns programmable wait-state acks.
- Forwards register traffic to the controller CPU over a command / data / bus-master handshake with real status readback.
- Sits between the N64 bus arbiter (if_n64_bus) and the CPU-side DD interface (if_dd.n64 signals).

---
 rtl/n64_dd_regs_pkg.sv | 29 ++
 rtl/n64_dd_regs_if.sv | 21 ++
 rtl/n64_dd_bus_slave.sv | 90 +++++++++
 rtl/n64_dd_regs.sv | 135 +++++++++++++
 tb/tb_n64_dd_regs.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_dd_regs_pkg.sv
// Shared types and register map for the 64DD register responder.
package dd_pkg;

    // Bus access sequencing states
    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_WAIT
    } e_state;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    // Register byte offsets inside the DD window
    localparam int unsigned REG_DATA   = 32'h00;
    localparam int unsigned REG_STATUS = 32'h08;
    localparam int unsigned REG_BM     = 32'h0C;
    localparam int unsigned REG_ID     = 32'h10;

    // STATUS bit positions
    localparam int unsigned ST_BUSY = 15;
    localparam int unsigned ST_IRQ  = 14;

    // Byte offset to halfword index, as seen on address[ADDR_W:1]
    function automatic int unsigned hw_index(input int unsigned byte_off);
        return byte_off >> 1;
    endfunction

endpackage

// File: rtl/n64_dd_regs_if.sv
// N64 PI bus arbiter side of the 64DD register window.
interface n64_dd_regs_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              bus_request;
    logic              bus_write;
    logic [ADDR_W:0]   bus_address;
    logic [15:0]       bus_wdata;
    logic [15:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_request, bus_write, bus_address, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/n64_dd_bus_slave.sv
// Request latch, wait-state counter and ack/rdata gating for the DD window.
module n64_dd_bus_slave
    import dd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ACK_DELAY = 1
) (
    input  logic                clk,
    input  logic                reset,
    n64_dd_regs_if.slave        bus,
    input  logic [DATA_W-1:0]   rd_value,
    output logic                commit,
    output logic [ADDR_W-1:0]   addr_hw,
    output logic                write,
    output logic [DATA_W-1:0]   wdata
);

    e_state             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    // Byte-lane bit of the address carries no information for halfword registers
    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.bus_address[0];

    // Next-state and latch logic; requests only accepted in S_IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.bus_request) begin
                    addr_d  = bus.bus_address[ADDR_W:1];
                    write_d = bus.bus_write;
                    wdata_d = bus.bus_wdata;
                    cnt_d   = CNT_W'(ACK_DELAY - 1);
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; ack is registered so it lands in the S_WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = ack_q ? rd_value : '0;
    assign commit        = ack_q;
    assign addr_hw       = addr_q;
    assign write         = write_q;
    assign wdata         = wdata_q;

endmodule

// File: rtl/n64_dd_regs.sv
// 64DD register responder: decodes the PI DD window, returns wait-state acks
// and forwards command / data / bus-master traffic to the controller CPU.
// Optional command-complete interrupt enabled by defining N64_DD_IRQ_EN.
module n64_dd_regs
    import dd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ACK_DELAY = 1,
    parameter logic [15:0] ID_VALUE  = 16'h0003
) (
    input  logic                clk,
    input  logic                reset,
    n64_dd_regs_if.slave        bus,
    input  logic                n64_hard_reset,
    output logic                hard_reset,
    output logic                cmd_request,
    input  logic                cmd_ack,
    output logic [7:0]          command,
    input  logic [DATA_W-1:0]   status,
    output logic [DATA_W-1:0]   data_input,
    input  logic [DATA_W-1:0]   data_output,
    output logic                bm_request,
    output logic [DATA_W-1:0]   bm_control,
    input  logic [DATA_W-1:0]   bm_status,
    output logic                irq
);

    localparam logic [ADDR_W-1:0] HW_DATA   = ADDR_W'(hw_index(REG_DATA));
    localparam logic [ADDR_W-1:0] HW_STATUS = ADDR_W'(hw_index(REG_STATUS));
    localparam logic [ADDR_W-1:0] HW_BM     = ADDR_W'(hw_index(REG_BM));
    localparam logic [ADDR_W-1:0] HW_ID     = ADDR_W'(hw_index(REG_ID));

    logic                commit;
    logic [ADDR_W-1:0]   addr_hw;
    logic                write;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rd_value;
    logic [DATA_W-1:0]   status_word;
    logic                wr_data, wr_cmd, wr_bm;

    n64_dd_bus_slave #(
        .ADDR_W    (ADDR_W),
        .ACK_DELAY (ACK_DELAY)
    ) u_bus_slave (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rd_value (rd_value),
        .commit   (commit),
        .addr_hw  (addr_hw),
        .write    (write),
        .wdata    (wdata)
    );

    // Write side-effects commit in the ack cycle
    assign wr_data = commit && write && (addr_hw == HW_DATA);
    assign wr_cmd  = commit && write && (addr_hw == HW_STATUS);
    assign wr_bm   = commit && write && (addr_hw == HW_BM);

    // STATUS: busy flag on top, interrupt or CPU bit 14, CPU low bits
    always_comb begin
        status_word        = '0;
        status_word[13:0]  = status[13:0];
`ifdef N64_DD_IRQ_EN
        status_word[ST_IRQ] = irq;
`else
        status_word[ST_IRQ] = status[14];
`endif
        status_word[ST_BUSY] = cmd_request;
    end

    // CPU drives the busy bit of its own status word only through cmd_request
    logic unused_status;
`ifdef N64_DD_IRQ_EN
    assign unused_status = status[15] ^ status[14];
`else
    assign unused_status = status[15];
`endif

    // Read mux; odd halfwords and unmapped offsets return zero
    always_comb begin
        rd_value = '0;
        case (addr_hw)
            HW_DATA:   rd_value = data_output;
            HW_STATUS: rd_value = status_word;
            HW_BM:     rd_value = bm_status;
            HW_ID:     rd_value = ID_VALUE;
            default:   rd_value = '0;
        endcase
    end

    // CPU-facing registers; cmd_ack and hard reset win over a new command
    always_ff @(posedge clk) begin
        if (reset) begin
            hard_reset  <= 1'b0;
            cmd_request <= 1'b0;
            command     <= '0;
            data_input  <= '0;
            bm_request  <= 1'b0;
            bm_control  <= '0;
        end else begin
            hard_reset <= n64_hard_reset;
            bm_request <= 1'b0;
            if (wr_data) begin
                data_input <= wdata;
            end
            if (wr_bm) begin
                bm_control <= wdata;
                bm_request <= 1'b1;
            end
            if (hard_reset || cmd_ack) begin
                cmd_request <= 1'b0;
            end else if (wr_cmd && !cmd_request) begin
                cmd_request <= 1'b1;
                command     <= wdata[15:8];
            end
        end
    end

`ifdef N64_DD_IRQ_EN
    // Command-complete interrupt, cleared by BM_CONTROL bit 0 or hard reset
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (hard_reset || (wr_bm && wdata[0])) begin
            irq <= 1'b0;
        end else if (cmd_ack) begin
            irq <= 1'b1;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_n64_dd_regs.sv
// Self-checking bench for n64_dd_regs with ACK_DELAY=3.
module tb_n64_dd_regs;
    import dd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        n64_hard_reset;
    logic        hard_reset;
    logic        cmd_request;
    logic        cmd_ack;
    logic [7:0]  command;
    logic [15:0] status;
    logic [15:0] data_input;
    logic [15:0] data_output;
    logic        bm_request;
    logic [15:0] bm_control;
    logic [15:0] bm_status;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    n64_dd_regs_if #(.ADDR_W(5)) bus_if ();

    n64_dd_regs #(
        .ADDR_W    (5),
        .ACK_DELAY (3),
        .ID_VALUE  (16'h0003)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if),
        .n64_hard_reset (n64_hard_reset),
        .hard_reset     (hard_reset),
        .cmd_request    (cmd_request),
        .cmd_ack        (cmd_ack),
        .command        (command),
        .status         (status),
        .data_input     (data_input),
        .data_output    (data_output),
        .bm_request     (bm_request),
        .bm_control     (bm_control),
        .bm_status      (bm_status),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // One bus access; entered and left at posedge+1. Reads push the expected
    // value on the scoreboard and pop it when the ack arrives.
    task automatic bus_access(input logic wr, input logic [5:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd, input logic with_cmd_ack);
        int   lat;
        logic got;
        logic [15:0] exp;
        if (!wr) exp_q.push_back(exp_rd);
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = wr;
        bus_if.bus_address = addr;
        bus_if.bus_wdata   = wd;
        @(posedge clk); #1;
        bus_if.bus_request = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 20) begin
            @(negedge clk);
            if (bus_if.bus_ack === 1'b1) begin
                got = 1'b1;
                if (with_cmd_ack) cmd_ack = 1'b1;
            end else begin
                checks++;
                if (bus_if.bus_rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL rdata_idle addr=%h: got %h expected 0000", addr, bus_if.bus_rdata);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout addr=%h: no ack within 20 cycles", addr);
            if (!wr) void'(exp_q.pop_front());
        end else begin
            if (lat != 4) begin
                errors++;
                $display("FAIL ack_latency addr=%h: got %0d expected 4", addr, lat);
            end
            if (!wr) begin
                exp = exp_q.pop_front();
                checks++;
                if (bus_if.bus_rdata !== exp) begin
                    errors++;
                    $display("FAIL rdata addr=%h: got %h expected %h", addr, bus_if.bus_rdata, exp);
                end
            end
            @(posedge clk); #1;
            cmd_ack = 1'b0;
            checks++;
            if (bus_if.bus_ack !== 1'b0) begin
                errors++;
                $display("FAIL ack_width addr=%h: ack still %b one cycle later", addr, bus_if.bus_ack);
            end
        end
    endtask

    task automatic pulse_cmd_ack();
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus_if.bus_ack, bus_if.bus_rdata, hard_reset, cmd_request, command, data_input,
             bm_request, bm_control, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rdata=%h hr=%b cr=%b cmd=%h di=%h bmr=%b bmc=%h irq=%b expected all 0",
                     bus_if.bus_ack, bus_if.bus_rdata, hard_reset, cmd_request, command,
                     data_input, bm_request, bm_control, irq);
        end
    endtask

    task automatic test_id_read();
        bus_access(1'b0, 6'h10, 16'h0, 16'h0003, 1'b0);
        bus_access(1'b0, 6'h11, 16'h0, 16'h0003, 1'b0);
        bus_access(1'b0, 6'h12, 16'h0, 16'h0000, 1'b0);
    endtask

    task automatic test_data();
        data_output = 16'h5A5A;
        bus_access(1'b1, 6'h00, 16'hBEEF, 16'h0, 1'b0);
        checks++;
        if (data_input !== 16'hBEEF) begin
            errors++;
            $display("FAIL data_input: got %h expected beef", data_input);
        end
        bus_access(1'b0, 6'h00, 16'h0, 16'h5A5A, 1'b0);
        bus_access(1'b1, 6'h02, 16'h1111, 16'h0, 1'b0);
        checks++;
        if (data_input !== 16'hBEEF) begin
            errors++;
            $display("FAIL odd_write_ignored: data_input %h expected beef", data_input);
        end
    endtask

    task automatic test_command();
        status = 16'h0040;
        bus_access(1'b1, 6'h08, 16'h1200, 16'h0, 1'b0);
        checks++;
        if (cmd_request !== 1'b1 || command !== 8'h12) begin
            errors++;
            $display("FAIL cmd_latch: cr=%b cmd=%h expected 1 12", cmd_request, command);
        end
        bus_access(1'b0, 6'h08, 16'h0, 16'h8040, 1'b0);
        bus_access(1'b1, 6'h08, 16'h3400, 16'h0, 1'b0);
        checks++;
        if (command !== 8'h12) begin
            errors++;
            $display("FAIL cmd_busy_drop: cmd=%h expected 12", command);
        end
        pulse_cmd_ack();
        checks++;
        if (cmd_request !== 1'b0) begin
            errors++;
            $display("FAIL cmd_ack_clear: cr=%b expected 0", cmd_request);
        end
`ifdef N64_DD_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: irq=%b expected 1", irq);
        end
        bus_access(1'b0, 6'h08, 16'h0, 16'h4040, 1'b0);
`else
        bus_access(1'b0, 6'h08, 16'h0, 16'h0040, 1'b0);
`endif
        bus_access(1'b1, 6'h08, 16'h3400, 16'h0, 1'b1);
        checks++;
        if (command !== 8'h12 || cmd_request !== 1'b0) begin
            errors++;
            $display("FAIL cmd_coincident_drop: cmd=%h cr=%b expected 12 0", command, cmd_request);
        end
    endtask

    task automatic test_bm();
        bm_status = 16'hA55A;
        bus_access(1'b1, 6'h0C, 16'h0005, 16'h0, 1'b0);
        checks++;
        if (bm_request !== 1'b1 || bm_control !== 16'h0005) begin
            errors++;
            $display("FAIL bm_write: bmr=%b bmc=%h expected 1 0005", bm_request, bm_control);
        end
        @(posedge clk); #1;
        checks++;
        if (bm_request !== 1'b0) begin
            errors++;
            $display("FAIL bm_pulse_width: bmr=%b expected 0", bm_request);
        end
`ifdef N64_DD_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b expected 0", irq);
        end
`endif
        bus_access(1'b0, 6'h0E, 16'h0, 16'h0000, 1'b0);
        bus_access(1'b0, 6'h0C, 16'h0, 16'hA55A, 1'b0);
    endtask

    task automatic test_hard_reset();
        bus_access(1'b1, 6'h08, 16'h7800, 16'h0, 1'b0);
        n64_hard_reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (hard_reset !== 1'b1 || cmd_request !== 1'b0 || command !== 8'h78) begin
            errors++;
            $display("FAIL hard_reset_clear: hr=%b cr=%b cmd=%h expected 1 0 78", hard_reset, cmd_request, command);
        end
        bus_access(1'b1, 6'h08, 16'h9A00, 16'h0, 1'b0);
        checks++;
        if (cmd_request !== 1'b0 || command !== 8'h78) begin
            errors++;
            $display("FAIL hard_reset_cmd_drop: cr=%b cmd=%h expected 0 78", cmd_request, command);
        end
        n64_hard_reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hard_reset !== 1'b0) begin
            errors++;
            $display("FAIL hard_reset_release: hr=%b expected 0", hard_reset);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = 6'h10;
        @(posedge clk); #1;
        bus_if.bus_request = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.bus_ack !== 1'b0) seen = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_ack: ack seen after reset, expected none");
        end
        checks++;
        if (command !== 8'h00 || data_input !== 16'h0000 || bm_control !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_regs: cmd=%h di=%h bmc=%h expected 0", command, data_input, bm_control);
        end
        bus_access(1'b0, 6'h10, 16'h0, 16'h0003, 1'b0);
    endtask

    task automatic test_back_to_back();
        data_output = 16'h1357;
        bm_status   = 16'h2468;
        status      = 16'hFFFF;
        bus_access(1'b0, 6'h10, 16'h0, 16'h0003, 1'b0);
        bus_access(1'b0, 6'h00, 16'h0, 16'h1357, 1'b0);
        bus_access(1'b0, 6'h0C, 16'h0, 16'h2468, 1'b0);
        bus_access(1'b0, 6'h0A, 16'h0, 16'h0000, 1'b0);
        bus_access(1'b0, 6'h14, 16'h0, 16'h0000, 1'b0);
        bus_access(1'b0, 6'h3E, 16'h0, 16'h0000, 1'b0);
`ifdef N64_DD_IRQ_EN
        bus_access(1'b0, 6'h08, 16'h0, 16'h3FFF, 1'b0);
`else
        bus_access(1'b0, 6'h08, 16'h0, 16'h7FFF, 1'b0);
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset              = 1'b1;
        n64_hard_reset     = 1'b0;
        cmd_ack            = 1'b0;
        status             = 16'h0000;
        data_output        = 16'h0000;
        bm_status          = 16'h0000;
        bus_if.bus_request = 1'b0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = '0;
        bus_if.bus_wdata   = '0;
        @(posedge clk); #1;
        test_reset();
        test_id_read();
        test_data();
        test_command();
        test_bm();
        test_hard_reset();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
